cpu_trace_checker: RTL and testbench
====================================

Name: cpu_trace_checker

Overview:
- Character-serial recogniser for CPU write-back trace lines.
- Consumes one ASCII character per clock on `char` and classifies each completed line as a register write, a memory write, or invalid.
- Sits between the trace text source (testbench UART/stream) and the comparison logic that consumes `format_type`.

Parameters:
- TIME_MAX_DIGITS, 4, maximum decimal digits in the time field (minimum is 1).
- GRF_MAX_DIGITS, 4, maximum decimal digits in the register-number field (minimum is 1).

Ports:
- clk  input  1  rising-edge clock; one character sampled per edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- char  input  8  ASCII character presented for the current cycle.
- format_type  output  2  2'b00 = no valid line; 2'b01 = register write; 2'b10 = memory write; 2'b11 is never driven.

Behaviour:
- Accepted grammar (each token is one character consumed per clock):
  - Register write: `^` T `@` P `:` S* `$` G S* `<=` S* D `#`
  - Memory write: `^` T `@` P `:` S* `*` A S* `<=` S* D `#`
- Field definitions:
  - T: 1..TIME_MAX_DIGITS decimal digits '0'-'9'.
  - P, A, D: exactly 8 hex digits each ('0'-'9', 'a'-'f').
  - G: 1..GRF_MAX_DIGITS decimal digits.
  - S*: zero or more ASCII spaces (0x20).
- FSM states: IDLE, TIME, PC, COLON, SP1, GRF, ADDR, SP2, LT, EQ, SP3, DATA, OK_REG, OK_MEM. A 4-bit digit counter tracks the digits consumed in the current field.
- Transitions:
  - `^` received in any state → TIME with count=0. This restarts the line and abandons any partial parse.
  - Any character that violates the grammar → IDLE. Output is 00 until the next `^`.
  - Overflowing a field's digit limit, or a field delimiter arriving with too few digits, is a violation.
  - `#` accepted in DATA after exactly 8 digits → OK_REG or OK_MEM, depending on whether `$` or `*` was taken.
- Output timing:
  - format_type is a Moore output decoded from state: 01 in OK_REG, 10 in OK_MEM, 00 otherwise.
  - It is valid for exactly one cycle after the edge that samples `#`.
  - On the next edge the FSM leaves OK_*: to TIME if char is `^`, else to IDLE. Characters between lines are ignored.
- Reset:
  - While reset = 0, state is IDLE, count = 0 and format_type = 00, regardless of clk or char.
  - Asserting reset mid-line discards the partial line.
  - The first edge after release is processed normally.
- Uppercase hex A-F is invalid unless the optional feature is compiled in.

Optional Feature:
- Macro: CPU_CHECKER_UPPER_HEX_EN.
- Defined: 'A'-'F' are also accepted as hex digits in P, A and D.
- Undefined: only lowercase 'a'-'f' are accepted; uppercase is a grammar violation and sends the FSM to IDLE.

Test Plan:
- Release reset (0→1), then feed "^1024@00003 0fc:" … Correction: feed "^1024@000030fc:$2<=89abcdef#" → format_type = 01 for exactly one cycle after `#` is sampled; 00 on every other cycle.
- Feed "^6@ffffffff: *0000aa00 <=  12345678#" → 10 for one cycle. Feed the same line with 7 PC digits → stays 00.
- Feed "^12345@00000000:$1<=00000000#" (5 time digits) → 00. Feed "^@..." with an empty time field → 00.
- Feed "^1@00000000:$2<=0000" then "^3@00000000:$31<=deadbeef#" → the restart on `^` yields 01 for the second line only.
- Pull reset low mid-line after "^1@0000", release, then feed the remaining characters → 00. Hold reset low while feeding a full valid line → 00 throughout.
- Feed "^1@00000000:$1<=DEADBEEF#" → 00 without CPU_CHECKER_UPPER_HEX_EN; 01 with it defined.

Source files
------------

// File: rtl/cpu_trace_checker.sv
// Character-serial recogniser for CPU write-back trace lines; classifies each line as register write, memory write or invalid.
// Define CPU_CHECKER_UPPER_HEX_EN to also accept 'A'-'F' in the PC, address and data fields.
module cpu_trace_checker #(
    parameter int TIME_MAX_DIGITS = 4,
    parameter int GRF_MAX_DIGITS  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type
);

    typedef enum logic [3:0] {
        IDLE, TIME, PC, COLON, SP1, GRF, ADDR, SP2,
        LT, EQ, SP3, DATA, OK_REG, OK_MEM
    } state_t;

    localparam logic [3:0] TIME_MAX = 4'(TIME_MAX_DIGITS);
    localparam logic [3:0] GRF_MAX  = 4'(GRF_MAX_DIGITS);
    localparam logic [3:0] HEX_LEN  = 4'd8;

    localparam logic [7:0] CH_CARET = 8'h5E;
    localparam logic [7:0] CH_AT    = 8'h40;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_LT    = 8'h3C;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_HASH  = 8'h23;

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
`ifdef CPU_CHECKER_UPPER_HEX_EN
        return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46));
`else
        return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
`endif
    endfunction

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       is_mem_q, is_mem_d;
    logic [3:0] cnt_inc;

    assign cnt_inc = count_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_mem_d = is_mem_q;
        if (char == CH_CARET) begin
            state_d = TIME;
            count_d = 4'd0;
        end else begin
            // Anything not explicitly accepted below is a grammar violation.
            state_d = IDLE;
            count_d = 4'd0;
            case (state_q)
                TIME: begin
                    if (is_dec(char) && (count_q < TIME_MAX)) begin
                        state_d = TIME;
                        count_d = cnt_inc;
                    end else if ((char == CH_AT) && (count_q != 4'd0)) begin
                        state_d = PC;
                    end
                end
                PC: begin
                    if (is_hex(char) && (count_q < HEX_LEN)) begin
                        state_d = PC;
                        count_d = cnt_inc;
                    end else if ((char == CH_COLON) && (count_q == HEX_LEN)) begin
                        state_d = COLON;
                    end
                end
                COLON, SP1: begin
                    if (char == CH_SPACE) begin
                        state_d = SP1;
                    end else if (char == CH_DOLLAR) begin
                        state_d  = GRF;
                        is_mem_d = 1'b0;
                    end else if (char == CH_STAR) begin
                        state_d  = ADDR;
                        is_mem_d = 1'b1;
                    end
                end
                GRF: begin
                    if (is_dec(char) && (count_q < GRF_MAX)) begin
                        state_d = GRF;
                        count_d = cnt_inc;
                    end else if ((char == CH_SPACE) && (count_q != 4'd0)) begin
                        state_d = SP2;
                    end else if ((char == CH_LT) && (count_q != 4'd0)) begin
                        state_d = LT;
                    end
                end
                ADDR: begin
                    if (is_hex(char) && (count_q < HEX_LEN)) begin
                        state_d = ADDR;
                        count_d = cnt_inc;
                    end else if ((char == CH_SPACE) && (count_q == HEX_LEN)) begin
                        state_d = SP2;
                    end else if ((char == CH_LT) && (count_q == HEX_LEN)) begin
                        state_d = LT;
                    end
                end
                SP2: begin
                    if (char == CH_SPACE) begin
                        state_d = SP2;
                    end else if (char == CH_LT) begin
                        state_d = LT;
                    end
                end
                LT: begin
                    if (char == CH_EQ) begin
                        state_d = EQ;
                    end
                end
                EQ, SP3: begin
                    if (char == CH_SPACE) begin
                        state_d = SP3;
                    end else if (is_hex(char)) begin
                        state_d = DATA;
                        count_d = 4'd1;
                    end
                end
                DATA: begin
                    if (is_hex(char) && (count_q < HEX_LEN)) begin
                        state_d = DATA;
                        count_d = cnt_inc;
                    end else if ((char == CH_HASH) && (count_q == HEX_LEN)) begin
                        state_d = is_mem_q ? OK_MEM : OK_REG;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= 4'd0;
            is_mem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_mem_q <= is_mem_d;
        end
    end

    assign format_type = (state_q == OK_REG) ? 2'b01 :
                         (state_q == OK_MEM) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed self-checking bench for cpu_trace_checker: feeds trace lines one character per clock.
module tb_cpu_trace_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] char;
    logic [1:0] format_type;
    int         errors = 0;
    int         checks = 0;

    cpu_trace_checker #(.TIME_MAX_DIGITS(4), .GRF_MAX_DIGITS(4)) dut (
        .clk(clk),
        .reset(reset),
        .char(char),
        .format_type(format_type)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output must be exp right after '#' is sampled and 00 after every other character.
    task automatic feed_line(input string name, input string s, input logic [1:0] exp, input bit tail);
        logic [1:0] want;
        for (int i = 0; i < s.len(); i++) begin
            char = s[i];
            @(posedge clk);
            #1;
            want = (s[i] == 8'h23) ? exp : 2'b00;
            checks++;
            if (format_type !== want) begin
                errors++;
                $display("FAIL %s char %0d: format_type=%b expected %b", name, i, format_type, want);
            end
        end
        if (tail) begin
            char = 8'h20;
            @(posedge clk);
            #1;
            checks++;
            if (format_type !== 2'b00) begin
                errors++;
                $display("FAIL %s tail: format_type=%b expected 00", name, format_type);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        char  = 8'h00;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (format_type !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: format_type=%b expected 00", format_type);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (format_type !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: format_type=%b expected 00", format_type);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reg_write();
        feed_line("reg_basic", "^1024@000030fc:$2<=89abcdef#", 2'b01, 1'b1);
        feed_line("reg_spaces", "^9999@00000000:  $1234  <=   0000000f#", 2'b01, 1'b1);
        feed_line("grf_5dig", "^1@00000000:$12345<=00000000#", 2'b00, 1'b1);
        feed_line("grf_empty", "^1@00000000:$<=00000000#", 2'b00, 1'b1);
    endtask

    task automatic test_mem_write();
        feed_line("mem_basic", "^6@ffffffff: *0000aa00 <=  12345678#", 2'b10, 1'b1);
        feed_line("pc_7dig", "^6@fffffff: *0000aa00 <=  12345678#", 2'b00, 1'b1);
        feed_line("addr_9dig", "^6@ffffffff:*0000aa001<=12345678#", 2'b00, 1'b1);
        feed_line("data_7dig", "^6@ffffffff:*0000aa00<=1234567#", 2'b00, 1'b1);
        feed_line("data_9dig", "^6@ffffffff:*0000aa00<=123456789#", 2'b00, 1'b1);
    endtask

    task automatic test_time_field();
        feed_line("time_5dig", "^12345@00000000:$1<=00000000#", 2'b00, 1'b1);
        feed_line("time_empty", "^@00000000:$1<=00000000#", 2'b00, 1'b1);
        feed_line("bad_char", "^1@00000000:$1<-00000000#", 2'b00, 1'b1);
    endtask

    task automatic test_restart();
        feed_line("restart_a", "^1@00000000:$2<=0000", 2'b00, 1'b0);
        feed_line("restart_b", "^3@00000000:$31<=deadbeef#", 2'b01, 1'b1);
    endtask

    task automatic test_back_to_back();
        feed_line("b2b_a", "^1@00000000:$1<=00000001#", 2'b01, 1'b0);
        feed_line("b2b_b", "^2@00000004:*00000010<=00000002#", 2'b10, 1'b0);
        feed_line("b2b_stray", "@00000000:$1<=00000000#", 2'b00, 1'b1);
    endtask

    task automatic test_reset_mid_line();
        feed_line("rst_mid_a", "^1@0000", 2'b00, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        feed_line("rst_mid_b", "0000:$1<=00000000#", 2'b00, 1'b1);
        reset = 1'b0;
        feed_line("rst_held", "^1@00000000:$1<=00000000#", 2'b00, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        feed_line("rst_async_ok", "^1@00000000:$1<=00000000#", 2'b01, 1'b0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (format_type !== 2'b00) begin
            errors++;
            $display("FAIL rst_async_clear: format_type=%b expected 00", format_type);
        end
        @(negedge clk);
        reset = 1'b1;
        feed_line("after_release", "^7@00000000:$3<=00000000#", 2'b01, 1'b1);
    endtask

    task automatic test_upper_hex();
`ifdef CPU_CHECKER_UPPER_HEX_EN
        feed_line("upper_hex", "^1@00000000:$1<=DEADBEEF#", 2'b01, 1'b1);
`else
        feed_line("upper_hex", "^1@00000000:$1<=DEADBEEF#", 2'b00, 1'b1);
`endif
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_mem_write();
        test_time_field();
        test_restart();
        test_back_to_back();
        test_reset_mid_line();
        test_upper_hex();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
